grid_fetch_arbiter: RTL
=======================

Name: grid_fetch_arbiter

Overview:
- Shares one single-port 1024x2 playfield grid RAM between two users:
  - the pixel renderer, which feeds the 12-bit rgb input of the VGA display block;
  - the snake game logic, which writes and reads cells.
- Runs its own 800x525 raster counters (640x480 active, 25 MHz) and fetches one 20x20-pixel cell per 20 pixels ahead of the beam.
- Game accesses use the remaining RAM cycles, arbitrated round-robin between writes and reads.

Parameters:
- COLOR_EMPTY, 12'h000, rgb for cell code 0
- COLOR_SNAKE, 12'h0F0, rgb for cell code 1
- COLOR_FOOD, 12'hF00, rgb for cell code 2
- COLOR_WALL, 12'h888, rgb for cell code 3

Ports:
- clk25  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-high
- mem_addr  out  10  grid RAM address = row*32+col
- mem_we  out  1  grid RAM write enable
- mem_wdata  out  2  grid RAM write data
- mem_rdata  in  2  grid RAM read data, valid the cycle after address (registered RAM)
- wr_req  in  1  game write request, held until wr_ack
- wr_addr  in  10  game write cell address
- wr_data  in  2  game write cell code
- wr_ack  out  1  one-cycle pulse, write issued this cycle
- rd_req  in  1  game read request, held until rd_ack
- rd_addr  in  10  game read cell address
- rd_ack  out  1  one-cycle pulse, read issued this cycle
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  2  game read result
- rgb  out  12  pixel colour to display block, {R,G,B} 4 bits each
- frame_tick  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Interface: one clock, clk25; reset is synchronous and active-high.
- Raster counters h (0..799) and v (0..524):
  - h wraps 799->0 and increments v; v wraps 524->0.
  - Reset value is h=796, v=524, so the first fetch for pixel (0,0) is issued cleanly.
- Fetch slots:
  - A cycle is a fetch slot when (h+2) mod 800 is in {0,20,...,620} and the target line is active (<480).
  - The target line is v+1 (with wrap) when h>=798, otherwise v.
  - col = ((h+2) mod 800)/20; row = target_line/20.
  - In a fetch slot: mem_addr=row*32+col, mem_we=0; game requests are not granted.
- mem_rdata from a fetch slot is latched into cell_reg at the end of the next cycle, so cell_reg holds the cell for pixels 20c..20c+19.
- rgb is registered, latency 1: the cycle after counter (h,v), rgb = colour(cell_reg) if h<640 and v<480, else 12'h000.
- Free cycles (all non-fetch cycles, including all blanking):
  - If only wr_req is high: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - If only rd_req is high: mem_addr=rd_addr, rd_ack=1. Next cycle: rd_valid=1, rd_data=mem_rdata.
  - If both are high: grant the one not granted last; last_grant resets to "read", so the write wins first.
  - A requester may keep its req high after an ack to issue a new transaction on the next free cycle; back-to-back grants are allowed.
  - When idle: mem_we=0, mem_addr=0, mem_wdata=0.
- A write and a read to the same address are serialized in grant order. A read granted after a write returns the new data.
- frame_tick=1 for exactly one cycle, the cycle with h=0, v=480.
- Reset values:
  - rgb, wr_ack, rd_ack, rd_valid, rd_data, frame_tick, mem_we, mem_wdata, mem_addr all 0
  - cell_reg = 0
- Reset mid-operation: the rd_valid for a read granted in the cycle before reset is suppressed; no partial state survives.
- Worst-case game access latency in the active region is 2 cycles when both requesters are active: 1 blocked fetch slot plus 1 round-robin loss.

Test Plan:
1. Reset, preload RAM cell 0 = 1 and cell 1 = 2, run one frame -> rgb=12'h0F0 for pixels 0..19 of lines 0..19; 12'hF00 for pixels 20..39; 12'h000 for h>=640; frame_tick once per 420000 cycles.
2. Hold wr_req with wr_addr=33, wr_data=3 across a fetch slot (h=18, v=5) -> no ack at h=18; wr_ack and mem_we at h=19; mem_addr=33, mem_wdata=3; next frame pixels 20..39 of lines 20..39 show 12'h888.
3. wr_req and rd_req held continuously during blanking -> acks alternate wr, rd, wr, ...; each rd_valid arrives exactly 1 cycle after its rd_ack.
4. Write cell 100=2, then immediately read cell 100 -> rd_data=2 with rd_valid the cycle after rd_ack.
5. Sweep a full frame -> mem_we never high in a fetch slot; exactly 32x480 fetch slots per frame.
6. Assert reset 1 cycle after rd_ack -> no rd_valid; h=796, v=524; all outputs 0 next cycle.

Source files
------------

// File: rtl/grid_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grid_fetch_arbiter
// Description : Shares a single-port 1024x2 playfield grid RAM between the
//               pixel renderer and the snake game logic. Runs its own
//               800x525 raster, fetches one 20x20 cell ahead of the beam
//               every 20 pixels, and gives the remaining RAM cycles to game
//               writes and reads with round-robin arbitration.
// Ports       : clk25              25 MHz pixel clock
//               reset              synchronous, active-high
//               mem_addr/we/wdata  grid RAM command (addr = row*32+col)
//               mem_rdata          grid RAM read data, one cycle after addr
//               wr_req/addr/data   game write request, held until wr_ack
//               wr_ack             pulse: write issued this cycle
//               rd_req/addr        game read request, held until rd_ack
//               rd_ack             pulse: read issued this cycle
//               rd_valid/rd_data   read result, cycle after rd_ack
//               rgb                registered {R,G,B} pixel colour
//               frame_tick         pulse at h=0, v=480
// Revision    : 1.0 - initial release
// ============================================================================
module grid_fetch_arbiter #(
    parameter logic [11:0] COLOR_EMPTY = 12'h000,
    parameter logic [11:0] COLOR_SNAKE = 12'h0F0,
    parameter logic [11:0] COLOR_FOOD  = 12'hF00,
    parameter logic [11:0] COLOR_WALL  = 12'h888
) (
    input  logic        clk25,
    input  logic        reset,
    output logic [9:0]  mem_addr,
    output logic        mem_we,
    output logic [1:0]  mem_wdata,
    input  logic [1:0]  mem_rdata,
    input  logic        wr_req,
    input  logic [9:0]  wr_addr,
    input  logic [1:0]  wr_data,
    output logic        wr_ack,
    input  logic        rd_req,
    input  logic [9:0]  rd_addr,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [1:0]  rd_data,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    localparam logic [9:0] c_H_LAST       = 10'd799;
    localparam logic [9:0] c_V_LAST       = 10'd524;
    localparam logic [9:0] c_H_RESET      = 10'd796;
    localparam logic [9:0] c_V_RESET      = 10'd524;
    localparam logic [9:0] c_H_ACTIVE     = 10'd640;
    localparam logic [9:0] c_V_ACTIVE     = 10'd480;
    localparam logic [9:0] c_H_WRAP_AHEAD = 10'd798;
    localparam logic [9:0] c_LAST_FETCH   = 10'd620;
    localparam logic [9:0] c_CELL_PIX     = 10'd20;

    logic [9:0]  r_hCount;
    logic [9:0]  r_vCount;
    logic        r_fetchPend;
    logic [1:0]  r_cell;
    logic [11:0] r_rgb;
    logic        r_rdPend;
    logic        r_lastGrantWr;

    logic [9:0]  w_hAhead;
    logic [9:0]  w_tgtLine;
    logic        w_fetchSlot;
    logic [4:0]  w_col;
    logic [4:0]  w_row;
    logic        w_free;
    logic        w_wrGrant;
    logic        w_rdGrant;
    logic [11:0] w_cellColor;

    // Fetch look-ahead: the slot two pixels before a cell boundary loads the
    // RAM so the data is in r_cell exactly when the beam reaches the cell.
    always_comb begin
        w_hAhead  = (r_hCount >= c_H_WRAP_AHEAD) ? (r_hCount - c_H_WRAP_AHEAD)
                                                 : (r_hCount + 10'd2);
        w_tgtLine = r_vCount;
        if (r_hCount >= c_H_WRAP_AHEAD) begin
            w_tgtLine = (r_vCount == c_V_LAST) ? 10'd0 : (r_vCount + 10'd1);
        end
        w_fetchSlot = ((w_hAhead % c_CELL_PIX) == 10'd0) &&
                      (w_hAhead <= c_LAST_FETCH) &&
                      (w_tgtLine < c_V_ACTIVE);
        w_col = 5'(w_hAhead / c_CELL_PIX);
        w_row = 5'(w_tgtLine / c_CELL_PIX);
    end

    // Round-robin: on contention the requester not granted last time wins.
    always_comb begin
        w_free    = !w_fetchSlot && !reset;
        w_wrGrant = w_free && wr_req && (!rd_req || !r_lastGrantWr);
        w_rdGrant = w_free && rd_req && !w_wrGrant;
    end

    always_comb begin
        mem_addr  = 10'd0;
        mem_we    = 1'b0;
        mem_wdata = 2'd0;
        if (!reset && w_fetchSlot) begin
            mem_addr = {w_row, w_col};
        end else if (w_wrGrant) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
        end else if (w_rdGrant) begin
            mem_addr = rd_addr;
        end
    end

    always_comb begin
        case (r_cell)
            2'd0:    w_cellColor = COLOR_EMPTY;
            2'd1:    w_cellColor = COLOR_SNAKE;
            2'd2:    w_cellColor = COLOR_FOOD;
            default: w_cellColor = COLOR_WALL;
        endcase
    end

    assign wr_ack     = w_wrGrant;
    assign rd_ack     = w_rdGrant;
    // Gating with reset drops the result of a read granted just before reset.
    assign rd_valid   = r_rdPend && !reset;
    assign rd_data    = rd_valid ? mem_rdata : 2'd0;
    assign rgb        = r_rgb;
    assign frame_tick = !reset && (r_hCount == 10'd0) && (r_vCount == c_V_ACTIVE);

    always_ff @(posedge clk25) begin
        if (reset) begin
            r_hCount      <= c_H_RESET;
            r_vCount      <= c_V_RESET;
            r_fetchPend   <= 1'b0;
            r_cell        <= 2'd0;
            r_rgb         <= 12'h000;
            r_rdPend      <= 1'b0;
            r_lastGrantWr <= 1'b0;
        end else begin
            if (r_hCount == c_H_LAST) begin
                r_hCount <= 10'd0;
                r_vCount <= (r_vCount == c_V_LAST) ? 10'd0 : (r_vCount + 10'd1);
            end else begin
                r_hCount <= r_hCount + 10'd1;
            end
            r_fetchPend <= w_fetchSlot;
            if (r_fetchPend) begin
                r_cell <= mem_rdata;
            end
            r_rgb <= ((r_hCount < c_H_ACTIVE) && (r_vCount < c_V_ACTIVE))
                     ? w_cellColor : 12'h000;
            r_rdPend <= w_rdGrant;
            if (w_wrGrant) begin
                r_lastGrantWr <= 1'b1;
            end else if (w_rdGrant) begin
                r_lastGrantWr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
